// File: rtl/dac_i2c_pkg.sv
// Shared constants for the I2C DAC target: register/command codes and FSM state encodings.
// The optional read-back path is enabled by defining READ_BACK_EN.
package dac_i2c_pkg;

  localparam logic [6:0] DEV_ADDR_DEF = 7'h60;

  localparam logic [4:0] DAC0_REG  = 5'd0;
  localparam logic [4:0] DAC1_REG  = 5'd1;
  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b11;

  typedef logic [3:0] state_t;

  // Each receive state is immediately followed by its ACK state, so "+1" reaches the ACK.
  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_ADDR      = 4'd1;
  localparam state_t ST_ADDR_ACK  = 4'd2;
  localparam state_t ST_CMD       = 4'd3;
  localparam state_t ST_CMD_ACK   = 4'd4;
  localparam state_t ST_DHI       = 4'd5;
  localparam state_t ST_DHI_ACK   = 4'd6;
  localparam state_t ST_DLO       = 4'd7;
  localparam state_t ST_DLO_ACK   = 4'd8;
  localparam state_t ST_WAIT_STOP = 4'd9;
  localparam state_t ST_TX_HI     = 4'd10;
  localparam state_t ST_TX_HI_ACK = 4'd11;
  localparam state_t ST_TX_LO     = 4'd12;
  localparam state_t ST_TX_LO_ACK = 4'd13;

  function automatic logic is_dac_reg(input logic [4:0] reg_code);
    return (reg_code == DAC0_REG) || (reg_code == DAC1_REG);
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus N-sample glitch filter for one open-drain I2C line,
// with registered level and single-clock rise/fall indications.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [3:0] LEN = 4'(FILTER_LEN);

  logic       sync1_q, sync2_q;
  logic       filt_q, filt_d;
  logic       prev_q;
  logic [3:0] cnt_q, cnt_d;

  // A new level is accepted only after LEN consecutive samples disagree with the current one.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q + 4'd1 >= LEN) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      prev_q  <= filt_q;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = filt_q;
  assign rise_o  = filt_q & ~prev_q;
  assign fall_o  = ~filt_q & prev_q;

endmodule

// File: rtl/i2c_dac_target.sv
// I2C target decoding MCP47FEB-style DAC write frames into two 16-bit channel registers.
// Define READ_BACK_EN to also answer read-command / repeated-START read transfers.
module i2c_dac_target
  import dac_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = DEV_ADDR_DEF,
  parameter int         FILTER_LEN = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic [15:0] ch0_value,
  output logic [15:0] ch1_value,
  output logic        ch0_update,
  output logic        ch1_update,
  output logic        busy,
  output logic        frame_error
);

`ifdef READ_BACK_EN
  localparam bit READ_BACK = 1'b1;
`else
  localparam bit READ_BACK = 1'b0;
`endif

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk(clk), .rst_n(rst), .line_i(scl_i),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk(clk), .rst_n(rst), .line_i(sda_i),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [7:0]  shadow_q, shadow_d;
  logic        sel_q, sel_d;
  logic        cmd_rd_q, cmd_rd_d;
  logic        tx_mode_q, tx_mode_d;
  logic        rd_armed_q, rd_armed_d;
  logic [15:0] tx_val_q, tx_val_d;
  logic [6:0]  tx_rest_q, tx_rest_d;
  logic        mack_q, mack_d;
  logic        sda_o_q, sda_o_d;
  logic [15:0] ch0_q, ch0_d, ch1_q, ch1_d;
  logic        upd0_q, upd0_d, upd1_q, upd1_d;
  logic        busy_q, busy_d;
  logic        ferr_q, ferr_d;

  logic       start_det, stop_det, pair_open;
  logic [7:0] rx_byte;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign rx_byte   = {shift_q, sda_lvl};
  assign pair_open = (state_q == ST_CMD_ACK) || (state_q == ST_DHI) ||
                     (state_q == ST_DHI_ACK) || (state_q == ST_DLO);

  always_comb begin
    // NOTE: every next-state variable gets a default first, so no path can infer a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    shadow_d   = shadow_q;
    sel_d      = sel_q;
    cmd_rd_d   = cmd_rd_q;
    tx_mode_d  = tx_mode_q;
    rd_armed_d = rd_armed_q;
    tx_val_d   = tx_val_q;
    tx_rest_d  = tx_rest_q;
    mack_d     = mack_q;
    sda_o_d    = sda_o_q;
    ch0_d      = ch0_q;
    ch1_d      = ch1_q;
    upd0_d     = 1'b0;
    upd1_d     = 1'b0;
    busy_d     = busy_q;
    ferr_d     = 1'b0;

    if (start_det || stop_det) begin
      // The first bit of a byte is already sampled when the START/STOP edge arrives.
      sda_o_d   = 1'b1;
      bit_cnt_d = '0;
      busy_d    = start_det;
      state_d   = start_det ? ST_ADDR : ST_IDLE;
      ferr_d    = pair_open || ((state_q == ST_CMD) && (bit_cnt_q > 4'd1));
      if (stop_det) rd_armed_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_CMD, ST_DHI, ST_DLO: begin
          if (scl_rise && (bit_cnt_q < 4'd8)) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              case (state_q)
                ST_ADDR: begin
                  if (rx_byte[7:1] != DEV_ADDR) begin
                    state_d   = ST_WAIT_STOP;
                    bit_cnt_d = '0;
                  end else if (!rx_byte[0]) begin
                    tx_mode_d = 1'b0;
                  end else if (READ_BACK && rd_armed_q) begin
                    tx_mode_d = 1'b1;
                  end else begin
                    state_d   = ST_WAIT_STOP;
                    bit_cnt_d = '0;
                    ferr_d    = 1'b1;
                  end
                end
                ST_CMD: begin
                  if (is_dac_reg(rx_byte[7:3]) && (rx_byte[2:1] == CMD_WRITE)) begin
                    sel_d    = rx_byte[3];
                    cmd_rd_d = 1'b0;
                  end else if (READ_BACK && is_dac_reg(rx_byte[7:3]) &&
                               (rx_byte[2:1] == CMD_READ)) begin
                    sel_d      = rx_byte[3];
                    cmd_rd_d   = 1'b1;
                    rd_armed_d = 1'b1;
                    tx_val_d   = rx_byte[3] ? ch1_q : ch0_q;
                  end else begin
                    state_d   = ST_WAIT_STOP;
                    bit_cnt_d = '0;
                    ferr_d    = 1'b1;
                  end
                end
                ST_DHI: shadow_d = rx_byte;
                default: begin
                  if (sel_q) begin
                    ch1_d  = {shadow_q, rx_byte};
                    upd1_d = 1'b1;
                  end else begin
                    ch0_d  = {shadow_q, rx_byte};
                    upd0_d = 1'b1;
                  end
                end
              endcase
            end
          end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
            sda_o_d   = 1'b0;
            bit_cnt_d = '0;
            state_d   = state_q + 4'd1;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            sda_o_d = 1'b1;
            state_d = ST_CMD;
            if (tx_mode_q) begin
              state_d   = ST_TX_HI;
              sda_o_d   = tx_val_q[15];
              tx_rest_d = tx_val_q[14:8];
            end
          end
        end
        ST_CMD_ACK: if (scl_fall) begin
          sda_o_d = 1'b1;
          state_d = cmd_rd_q ? ST_WAIT_STOP : ST_DHI;
        end
        ST_DHI_ACK: if (scl_fall) begin
          sda_o_d = 1'b1;
          state_d = ST_DLO;
        end
        ST_DLO_ACK: if (scl_fall) begin
          sda_o_d = 1'b1;
          state_d = ST_CMD;
        end
        ST_TX_HI, ST_TX_LO: begin
          if (scl_rise && (bit_cnt_q < 4'd8)) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_o_d   = 1'b1;
              bit_cnt_d = '0;
              state_d   = state_q + 4'd1;
            end else begin
              sda_o_d   = tx_rest_q[6];
              tx_rest_d = {tx_rest_q[5:0], 1'b0};
            end
          end
        end
        ST_TX_HI_ACK, ST_TX_LO_ACK: begin
          if (scl_rise) begin
            mack_d = ~sda_lvl;
          end else if (scl_fall) begin
            if (!mack_q) begin
              state_d = ST_WAIT_STOP;
            end else if (state_q == ST_TX_HI_ACK) begin
              state_d   = ST_TX_LO;
              sda_o_d   = tx_val_q[7];
              tx_rest_d = tx_val_q[6:0];
            end else begin
              state_d   = ST_TX_HI;
              sda_o_d   = tx_val_q[15];
              tx_rest_d = tx_val_q[14:8];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      shadow_q   <= '0;
      sel_q      <= 1'b0;
      cmd_rd_q   <= 1'b0;
      tx_mode_q  <= 1'b0;
      rd_armed_q <= 1'b0;
      tx_val_q   <= '0;
      tx_rest_q  <= '0;
      mack_q     <= 1'b0;
      sda_o_q    <= 1'b1;
      ch0_q      <= '0;
      ch1_q      <= '0;
      upd0_q     <= 1'b0;
      upd1_q     <= 1'b0;
      busy_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      shadow_q   <= shadow_d;
      sel_q      <= sel_d;
      cmd_rd_q   <= cmd_rd_d;
      tx_mode_q  <= tx_mode_d;
      rd_armed_q <= rd_armed_d;
      tx_val_q   <= tx_val_d;
      tx_rest_q  <= tx_rest_d;
      mack_q     <= mack_d;
      sda_o_q    <= sda_o_d;
      ch0_q      <= ch0_d;
      ch1_q      <= ch1_d;
      upd0_q     <= upd0_d;
      upd1_q     <= upd1_d;
      busy_q     <= busy_d;
      ferr_q     <= ferr_d;
    end
  end

  assign sda_o       = sda_o_q;
  assign ch0_value   = ch0_q;
  assign ch1_value   = ch1_q;
  assign ch0_update  = upd0_q;
  assign ch1_update  = upd1_q;
  assign busy        = busy_q;
  assign frame_error = ferr_q;

endmodule

// File: tb/tb_i2c_dac_target.sv
// Directed bench for i2c_dac_target: bit-banged I2C master on a wired-AND SDA line.
// The read-back sequence is exercised only when READ_BACK_EN is defined.
module tb_i2c_dac_target;

  localparam int Q = 8;  // clocks per quarter SCL period

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        sda_o;
  logic [15:0] ch0_value, ch1_value;
  logic        ch0_update, ch1_update, busy, frame_error;

  int checks = 0;
  int errors = 0;
  int n_upd0 = 0, n_upd1 = 0, n_ferr = 0;

  assign sda_line = sda_m & sda_o;

  i2c_dac_target #(.DEV_ADDR(7'h60), .FILTER_LEN(3)) dut (
    .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_line), .sda_o(sda_o),
    .ch0_value(ch0_value), .ch1_value(ch1_value),
    .ch0_update(ch0_update), .ch1_update(ch1_update),
    .busy(busy), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  // Pulse monitors count clocks high, so a one-clock strobe adds exactly 1.
  always @(negedge clk) begin
    if (ch0_update)  n_upd0++;
    if (ch1_update)  n_upd1++;
    if (frame_error) n_ferr++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic qd();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qd(); scl = 1'b1; qd(); sda_m = 1'b0; qd(); scl = 1'b0; qd();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qd(); scl = 1'b1; qd(); sda_m = 1'b1; qd(); qd();
  endtask

  task automatic write_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; qd(); scl = 1'b1; qd(); qd(); scl = 1'b0;
    end
    qd();
  endtask

  task automatic ack_bit(output logic ack);
    sda_m = 1'b1; qd(); scl = 1'b1; qd(); ack = ~sda_line; qd(); scl = 1'b0; qd();
  endtask

  task automatic send(input string tag, input logic [7:0] b, input logic exp_ack);
    logic ack;
    write_bits(b);
    ack_bit(ack);
    check(tag, {15'd0, ack}, {15'd0, exp_ack});
  endtask

  task automatic read_byte(output logic [7:0] b, input logic mack);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      qd(); scl = 1'b1; qd(); b[i] = sda_line; qd(); scl = 1'b0;
    end
    qd(); sda_m = ~mack; qd(); scl = 1'b1; qd(); qd(); scl = 1'b0; qd(); sda_m = 1'b1;
  endtask

  initial begin
    int u0, u1, fe;
    logic ack;
    logic [7:0] rd;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_sda_o", {15'd0, sda_o}, 16'd1);
    check("rst_ch0", ch0_value, 16'h0000);
    check("rst_ch1", ch1_value, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_ferr", {15'd0, frame_error}, 16'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Single write to DAC1; value must land before the ACK of the low byte
    u0 = n_upd0; u1 = n_upd1; fe = n_ferr;
    i2c_start();
    check("t1_busy", {15'd0, busy}, 16'd1);
    send("t1_addr_ack", 8'hC0, 1'b1);
    send("t1_cmd_ack", 8'h08, 1'b1);
    send("t1_dhi_ack", 8'h0A, 1'b1);
    write_bits(8'hBC);
    check("t1_ch1_before_ack", ch1_value, 16'h0ABC);
    ack_bit(ack);
    check("t1_dlo_ack", {15'd0, ack}, 16'd1);
    i2c_stop();
    check("t1_ch1", ch1_value, 16'h0ABC);
    check("t1_ch0", ch0_value, 16'h0000);
    check("t1_upd1", 16'(n_upd1 - u1), 16'd1);
    check("t1_upd0", 16'(n_upd0 - u0), 16'd0);
    check("t1_ferr", 16'(n_ferr - fe), 16'd0);
    check("t1_busy_end", {15'd0, busy}, 16'd0);

    // Continuous write: DAC0 then DAC1 in one frame
    u0 = n_upd0; u1 = n_upd1; fe = n_ferr;
    i2c_start();
    send("t2_addr", 8'hC0, 1'b1);
    send("t2_cmd0", 8'h00, 1'b1);
    send("t2_hi0", 8'h12, 1'b1);
    send("t2_lo0", 8'h34, 1'b1);
    check("t2_ch0_mid", ch0_value, 16'h1234);
    send("t2_cmd1", 8'h08, 1'b1);
    send("t2_hi1", 8'h56, 1'b1);
    send("t2_lo1", 8'h78, 1'b1);
    i2c_stop();
    check("t2_ch0", ch0_value, 16'h1234);
    check("t2_ch1", ch1_value, 16'h5678);
    check("t2_upd0", 16'(n_upd0 - u0), 16'd1);
    check("t2_upd1", 16'(n_upd1 - u1), 16'd1);
    check("t2_ferr", 16'(n_ferr - fe), 16'd0);

    // Foreign address: no ACK, bus stays busy, no error
    u0 = n_upd0; u1 = n_upd1; fe = n_ferr;
    i2c_start();
    send("t3_addr_nack", 8'hC2, 1'b0);
    check("t3_busy", {15'd0, busy}, 16'd1);
    send("t3_data_ignored", 8'h08, 1'b0);
    i2c_stop();
    check("t3_busy_end", {15'd0, busy}, 16'd0);
    check("t3_ferr", 16'(n_ferr - fe), 16'd0);
    check("t3_upd", 16'((n_upd0 - u0) + (n_upd1 - u1)), 16'd0);

    // Register 2: NACK on command, error pulse, later bytes ignored
    u0 = n_upd0; u1 = n_upd1; fe = n_ferr;
    i2c_start();
    send("t4_addr", 8'hC0, 1'b1);
    send("t4_cmd_nack", 8'h10, 1'b0);
    send("t4_data_nack", 8'h12, 1'b0);
    i2c_stop();
    check("t4_ferr", 16'(n_ferr - fe), 16'd1);
    check("t4_upd", 16'((n_upd0 - u0) + (n_upd1 - u1)), 16'd0);
    check("t4_ch0", ch0_value, 16'h1234);

    // Truncated pair: STOP after the high byte
    u0 = n_upd0; u1 = n_upd1; fe = n_ferr;
    i2c_start();
    send("t5_addr", 8'hC0, 1'b1);
    send("t5_cmd", 8'h00, 1'b1);
    send("t5_dhi", 8'hFF, 1'b1);
    i2c_stop();
    check("t5_ferr", 16'(n_ferr - fe), 16'd1);
    check("t5_upd0", 16'(n_upd0 - u0), 16'd0);
    check("t5_ch0", ch0_value, 16'h1234);

    // Reset during the DAC0 low-byte ACK
    i2c_start();
    send("t6_addr", 8'hC0, 1'b1);
    send("t6_cmd", 8'h00, 1'b1);
    send("t6_dhi", 8'h12, 1'b1);
    write_bits(8'h34);
    sda_m = 1'b1; qd(); scl = 1'b1; qd();
    check("t6_ack_driven", {15'd0, sda_line}, 16'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("t6_sda_released", {15'd0, sda_o}, 16'd1);
    check("t6_ch0_cleared", ch0_value, 16'h0000);
    check("t6_ch1_cleared", ch1_value, 16'h0000);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    scl = 1'b0; qd();
    i2c_stop();
    u1 = n_upd1; fe = n_ferr;
    i2c_start();
    send("t6b_addr", 8'hC0, 1'b1);
    send("t6b_cmd", 8'h08, 1'b1);
    send("t6b_dhi", 8'h0A, 1'b1);
    send("t6b_dlo", 8'hBC, 1'b1);
    i2c_stop();
    check("t6b_ch1", ch1_value, 16'h0ABC);
    check("t6b_ch0", ch0_value, 16'h0000);
    check("t6b_upd1", 16'(n_upd1 - u1), 16'd1);
    check("t6b_ferr", 16'(n_ferr - fe), 16'd0);

`ifdef READ_BACK_EN
    // Write DAC1, arm read-back, repeated START, read hi then lo
    fe = n_ferr;
    i2c_start();
    send("t7_addr", 8'hC0, 1'b1);
    send("t7_cmd", 8'h08, 1'b1);
    send("t7_dhi", 8'h0A, 1'b1);
    send("t7_dlo", 8'hBC, 1'b1);
    send("t7_rdcmd_ack", 8'h0E, 1'b1);
    i2c_start();
    send("t7_raddr_ack", 8'hC1, 1'b1);
    read_byte(rd, 1'b1);
    check("t7_read_hi", {8'd0, rd}, 16'h000A);
    read_byte(rd, 1'b0);
    check("t7_read_lo", {8'd0, rd}, 16'h00BC);
    i2c_stop();
    check("t7_ferr", 16'(n_ferr - fe), 16'd0);
    check("t7_busy_end", {15'd0, busy}, 16'd0);
`else
    // Without read-back, both read address and read command are refused with an error
    fe = n_ferr;
    i2c_start();
    send("t7_raddr_nack", 8'hC1, 1'b0);
    i2c_stop();
    check("t7_raddr_ferr", 16'(n_ferr - fe), 16'd1);
    fe = n_ferr;
    i2c_start();
    send("t7_addr", 8'hC0, 1'b1);
    send("t7_rdcmd_nack", 8'h0E, 1'b0);
    i2c_stop();
    check("t7_rdcmd_ferr", 16'(n_ferr - fe), 16'd1);
    check("t7_ch1_kept", ch1_value, 16'h0ABC);
    rd = 8'h00;
    check("t7_rd_unused", {8'd0, rd}, 16'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_dac_target.md
Name: i2c_dac_target

Overview:
I2C target (responder) that decodes the MCP47FEB-style write frames our DAC driver issues and holds the resulting channel values. It lets DAC-driving logic be looped back and checked on-chip, and lets one FPGA act as a virtual DAC for another. It samples raw SCL/SDA on the system clock, decodes START/STOP and bytes, ACKs valid frames and presents two 16-bit channel registers with update strobes.

Parameters:
DEV_ADDR, 7'h60, 7-bit target address that is ACKed.
FILTER_LEN, 3, number of consecutive equal samples needed to accept an SCL/SDA level change (range 1..8).

Ports:
clk  in  1  system clock, must be ≥16x SCL rate.
rst  in  1  synchronous, active-low reset.
scl_i  in  1  raw SCL pin level.
sda_i  in  1  raw SDA pin level.
sda_o  out  1  1 = release SDA (pad drives z), 0 = pull low.
ch0_value  out  16  DAC0 register.
ch1_value  out  16  DAC1 register.
ch0_update  out  1  one-clk pulse when ch0_value changes.
ch1_update  out  1  one-clk pulse when ch1_value changes.
busy  out  1  high from START until STOP or abort.
frame_error  out  1  one-clk pulse on NACKed or truncated frame.

Behaviour:
- Reset (rst=0 at clk edge): sda_o=1, ch*_value=0, strobes=0, busy=0, frame_error=0, FSM=IDLE, filters preset to 1.
- Input path: 2-flop sync, then FILTER_LEN glitch filter, then rise/fall detect on filtered SCL/SDA.
- START is SDA fall with SCL high. STOP is SDA rise with SCL high. Both are recognised in every state. Data bits are sampled on SCL rise, MSB first.
- FSM: IDLE -> ADDR -> ADDR_ACK -> CMD -> CMD_ACK -> DHI -> DHI_ACK -> DLO -> DLO_ACK -> CMD (continuous write). WAIT_STOP holds the bus released.
- ACK driving: sda_o=0 from the first clk after SCL falls following bit 8 until SCL falls after bit 9. NACK leaves sda_o=1.
- ADDR: address[7:1] == DEV_ADDR and R/W=0 gives ACK. Mismatch gives no ACK, WAIT_STOP, and no frame_error (the frame is not ours).
- CMD byte: [7:3] register, [2:1] command, [0] ignored. Register 0 or 1 with command 2'b00 gives ACK. Anything else gives NACK, frame_error pulse, WAIT_STOP.
- DHI: the byte is held in a shadow register and ACKed.
- DLO: on the 8th SCL rise, the selected ch*_value <= {shadow, byte} and the matching ch*_update pulses on the next clk. That is 1 clk latency from the last data bit, before the ACK. The ACK follows.
- STOP or START during CMD_ACK..DLO (pair incomplete): shadow discarded, no register update, frame_error pulse. FSM goes IDLE on STOP, ADDR on START.
- STOP or START in ADDR/CMD at bit 0, or after DLO_ACK: clean end, no error.
- Repeated START goes directly to ADDR.
- busy=1 from START detect through the clk of STOP detect; it drops on the following clk.
- sda_o is released within 1 clk of any STOP/START or reset.

Optional Feature:
READ_BACK_EN:
- Defined: command 2'b11 on register 0/1 is ACKed and the register is latched. A following repeated START with R/W=1 to DEV_ADDR enters TX_HI -> TX_HI_ACK -> TX_LO -> TX_LO_ACK. Bits are shifted on SCL fall. Master ACK continues with the next byte (hi, lo, hi...). Master NACK goes to WAIT_STOP.
- Undefined: R/W=1 and command 2'b11 are NACKed with frame_error.

Decomposition:
- Package dac_i2c_pkg: DEV_ADDR default, DAC0_REG/DAC1_REG codes, CMD_WRITE=2'b00 / CMD_READ=2'b11, FSM state enum.
- Sub-module i2c_line_filter (one instance per line): sync, glitch filter, rise/fall outputs.

Test Plan:
- Write 0x60, cmd 0x08, 0x0A, 0xBC, STOP: ch1_value=16'h0ABC, one ch1_update pulse, three ACKs plus the address ACK, ch0 unchanged.
- Continuous write {0x00,0x12,0x34,0x08,0x56,0x78}: ch0=16'h1234 then ch1=16'h5678, two strobes.
- Address 0x61: no ACK, busy still asserted until STOP, no error, no update.
- Cmd 0x10 (register 2): NACK on cmd, frame_error pulse. Later data ignored.
- cmd 0x00, 0xFF, STOP: no update, frame_error pulse, ch0 keeps its prior value.
- rst=0 during ch0 DLO ACK: sda_o=1 next clk, ch values 0. After release, the next full write succeeds. With READ_BACK_EN defined, a write of 0x0ABC followed by cmd 0x0E, repeated START, read returns 0x0A, 0xBC.
